// File: rtl/uart_rx_frame_ctrl_if.sv
// rtl/uart_rx_frame_ctrl_if.sv - signal bundle around the UART RX frame controller
//
// Purpose: groups the serial line, the frame configuration, the parity checker
//          handshake and the frame status outputs into one connection.
// Signals:
//   RX_IN       serial line, idle high
//   Prescale    oversampling ratio (8, 16 or 32)
//   PAR_EN      frame carries a parity bit
//   PAR_ERR     registered result from the downstream parity checker
//   S_BIT       majority-voted value of the current bit
//   P_DATA      deserialised data word
//   PAR_Chk_EN  strobe: parity bit is on S_BIT
//   STR_ERR     pulse: start glitch
//   STP_ERR     pulse: stop bit sampled low
//   DATA_VALID  pulse: good frame in P_DATA
//   BUSY        a frame is in progress
// Modports: slave = the frame controller, master = whatever drives the line.
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  PAR_ERR;
  logic                  S_BIT;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  PAR_Chk_EN;
  logic                  STR_ERR;
  logic                  STP_ERR;
  logic                  DATA_VALID;
  logic                  BUSY;

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_ERR,
    output S_BIT, P_DATA, PAR_Chk_EN, STR_ERR, STP_ERR, DATA_VALID, BUSY
  );

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_ERR,
    input  S_BIT, P_DATA, PAR_Chk_EN, STR_ERR, STP_ERR, DATA_VALID, BUSY
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame controller
//
// Purpose: bit timing, 3-sample majority voting, start/stop checking and
//          LSB-first deserialisation of one frame; parity checking is done by
//          a downstream checker fed through S_BIT / PAR_Chk_EN / P_DATA.
// Ports:
//   CLK  oversampling clock
//   RST  asynchronous active-high reset
//   rx   uart_rx_frame_ctrl_if.slave (line, config, checker handshake, status)
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  uart_rx_frame_ctrl_if.slave       rx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] E_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] E_TWO = PRESCALE_W'(2);
  localparam logic [BW-1:0]         B_ONE = BW'(1);
  localparam logic [BW-1:0]         B_LAST = BW'(DATA_WIDTH - 1);

  state_t                state_q;
  logic [PRESCALE_W-1:0] p_q;
  logic                  par_en_q;
  logic [PRESCALE_W-1:0] edge_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [1:0]            smp_q;
  logic                  s_bit_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  par_chk_en_q;
  logic                  str_err_q;
  logic                  stp_err_q;
  logic                  data_valid_q;

  // Bit-timing decode points, all relative to the latched prescale.
  logic [PRESCALE_W-1:0] half;
  logic                  at_smp_first, at_smp_mid, at_smp_last, at_cp, at_last;
  logic                  s_bit_d;

  assign half         = p_q >> 1;
  assign at_smp_first = (edge_cnt_q == half - E_ONE);
  assign at_smp_mid   = (edge_cnt_q == half);
  assign at_smp_last  = (edge_cnt_q == half + E_ONE);
  assign at_cp        = (edge_cnt_q == half + E_TWO);
  // With an illegal prescale of 0, p_q - 1 wraps to all ones, so the counter
  // still wraps and every state still has an exit.
  assign at_last      = (edge_cnt_q == p_q - E_ONE);

  // Third sample is taken straight from the line in the same cycle it is voted.
  assign s_bit_d = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx.RX_IN) | (smp_q[1] & rx.RX_IN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      p_q          <= '0;
      par_en_q     <= 1'b0;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      smp_q        <= 2'b11;
      s_bit_q      <= 1'b1;
      p_data_q     <= '0;
      par_chk_en_q <= 1'b0;
      str_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      par_chk_en_q <= 1'b0;
      str_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      data_valid_q <= 1'b0;

      if (state_q == IDLE) begin
        edge_cnt_q <= '0;
        bit_cnt_q  <= '0;
        if (!rx.RX_IN) begin
          state_q  <= START;
          p_q      <= rx.Prescale;
          par_en_q <= rx.PAR_EN;
        end
      end else begin
        edge_cnt_q <= at_last ? '0 : edge_cnt_q + E_ONE;
        if (at_smp_first) smp_q[0] <= rx.RX_IN;
        if (at_smp_mid)   smp_q[1] <= rx.RX_IN;
        if (at_smp_last)  s_bit_q  <= s_bit_d;

        case (state_q)
          START: begin
            if (at_cp && s_bit_q) begin
              str_err_q <= 1'b1;
              state_q   <= IDLE;
            end else if (at_last) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            if (at_cp) p_data_q <= {s_bit_q, p_data_q[DATA_WIDTH-1:1]};
            if (at_last) begin
              if (bit_cnt_q == B_LAST) state_q <= par_en_q ? PARITY : STOP;
              else                     bit_cnt_q <= bit_cnt_q + B_ONE;
            end
          end
          PARITY: begin
            // Raised one cycle early so the strobe sits exactly on the CP cycle.
            if (at_smp_last) par_chk_en_q <= 1'b1;
            if (at_last)     state_q <= STOP;
          end
          STOP: begin
            // Leave at CP so a start edge in the tail of the stop bit is caught.
            if (at_cp) begin
              stp_err_q    <= ~s_bit_q;
              data_valid_q <= s_bit_q & (~par_en_q | ~rx.PAR_ERR);
              state_q      <= IDLE;
            end else if (at_last) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx.S_BIT      = s_bit_q;
  assign rx.P_DATA     = p_data_q;
  assign rx.PAR_Chk_EN = par_chk_en_q;
  assign rx.STR_ERR    = str_err_q;
  assign rx.STP_ERR    = stp_err_q;
  assign rx.DATA_VALID = data_valid_q;
  assign rx.BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - self-checking bench for uart_rx_frame_ctrl
//
// Purpose: drives directed and random UART frames, predicts every output pulse
//          cycle from the frame timing rules, and compares recorded events.
module tb_uart_rx_frame_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_rx_frame_ctrl_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) rx_if ();

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK (CLK),
    .RST (RST),
    .rx  (rx_if)
  );

  int asrt_cnt = 0;
  int fail_cnt = 0;
  int cyc = 0;
  logic [DW-1:0] last_data = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Downstream even-parity checker stub: registers its verdict on the strobe.
  always @(posedge CLK or posedge RST) begin
    if (RST) rx_if.PAR_ERR <= 1'b0;
    else if (rx_if.PAR_Chk_EN) rx_if.PAR_ERR <= (^rx_if.P_DATA) ^ rx_if.S_BIT;
  end

  // Recorded events (cycle numbers) and expected events.
  int got_dv[$], got_str[$], got_stp[$], got_pce[$], got_rise[$], got_fall[$];
  int exp_dv[$], exp_str[$], exp_stp[$], exp_pce[$], exp_rise[$], exp_fall[$];
  int got_dvd[$], exp_dvd[$];
  logic busy_prev = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (rx_if.DATA_VALID) begin got_dv.push_back(cyc); got_dvd.push_back(int'(rx_if.P_DATA)); end
      if (rx_if.STR_ERR)    got_str.push_back(cyc);
      if (rx_if.STP_ERR)    got_stp.push_back(cyc);
      if (rx_if.PAR_Chk_EN) got_pce.push_back(cyc);
      if (rx_if.BUSY && !busy_prev) got_rise.push_back(cyc);
      if (!rx_if.BUSY && busy_prev) got_fall.push_back(cyc);
    end
    busy_prev = rx_if.BUSY;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    asrt_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cmp_q(input string tag, input int g[$], input int e[$]);
    int n;
    check({tag, "_count"}, 64'(g.size()), 64'(e.size()));
    n = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < n; i++) check(tag, 64'(g[i]), 64'(e[i]));
  endtask

  task automatic hold(input logic b, input int n);
    rx_if.RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_events();
    hold(1'b1, 3);
    cmp_q("data_valid", got_dv, exp_dv);
    cmp_q("p_data_at_valid", got_dvd, exp_dvd);
    cmp_q("str_err", got_str, exp_str);
    cmp_q("stp_err", got_stp, exp_stp);
    cmp_q("par_chk_en", got_pce, exp_pce);
    cmp_q("busy_rise", got_rise, exp_rise);
    cmp_q("busy_fall", got_fall, exp_fall);
    check("p_data_hold", 64'(rx_if.P_DATA), 64'(last_data));
    check("busy_idle", 64'(rx_if.BUSY), 64'd0);
    got_dv.delete(); got_dvd.delete(); got_str.delete(); got_stp.delete();
    got_pce.delete(); got_rise.delete(); got_fall.delete();
    exp_dv.delete(); exp_dvd.delete(); exp_str.delete(); exp_stp.delete();
    exp_pce.delete(); exp_rise.delete(); exp_fall.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  64'(rx_if.BUSY), 64'd0);
    check({tag, "_s_bit"}, 64'(rx_if.S_BIT), 64'd1);
    check({tag, "_p_data"}, 64'(rx_if.P_DATA), 64'd0);
    check({tag, "_pulses"}, 64'({rx_if.DATA_VALID, rx_if.STR_ERR, rx_if.STP_ERR, rx_if.PAR_Chk_EN}), 64'd0);
  endtask

  // fault: 0 none, 1 bad parity bit, 2 stop bit low, 3 start glitch of glen cycles.
  // glitch_bit: data bit that gets a one-cycle glitch on its middle sample (-1 none).
  // abort_bit: line bit (start = 0) during which RST is pulsed (-1 none).
  task automatic send_frame(input int p, input bit pe, input logic [DW-1:0] d,
                            input int fault, input int glen, input int glitch_bit,
                            input int abort_bit);
    int t0, nb, cp_stop;
    logic [DW+2:0] lb;
    rx_if.Prescale = PW'(p);
    rx_if.PAR_EN   = pe;
    t0 = cyc + 1;
    exp_rise.push_back(t0);
    if (fault == 3) begin
      hold(1'b0, glen);
      hold(1'b1, p + 3);
      exp_str.push_back(t0 + p/2 + 3);
      exp_fall.push_back(t0 + p/2 + 3);
      return;
    end
    lb = '1;
    lb[0] = 1'b0;
    lb[DW:1] = d;
    if (pe) lb[DW+1] = (^d) ^ (fault == 1);
    nb = pe ? DW + 3 : DW + 2;
    for (int k = 0; k < nb; k++) begin
      if (k == 1) begin
        // Mid-frame config changes must be ignored.
        rx_if.Prescale = PW'($urandom);
        rx_if.PAR_EN   = 1'($urandom);
      end
      if (k == abort_bit) begin
        hold(lb[k], p/2);
        RST = 1'b1;
        #1;
        check_reset_values("abort");
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        hold(1'b1, 4);
        last_data = '0;
        return;
      end
      if (k == nb - 1 && fault == 2) begin
        hold(1'b0, p/2 + 3);
        hold(1'b1, p - p/2 - 3);
      end else if (k == glitch_bit + 1) begin
        hold(lb[k], p/2 + 1);
        hold(~lb[k], 1);
        hold(lb[k], p - p/2 - 2);
      end else begin
        hold(lb[k], p);
      end
    end
    cp_stop = t0 + (nb - 1) * p + p/2 + 2;
    if (pe) exp_pce.push_back(t0 + (DW + 1) * p + p/2 + 2);
    if (fault == 2) exp_stp.push_back(cp_stop + 1);
    else if (!(pe && fault == 1)) begin
      exp_dv.push_back(cp_stop + 1);
      exp_dvd.push_back(int'(d));
    end
    exp_fall.push_back(cp_stop + 1);
    last_data = d;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, fault, gb;
    bit pe;
    rx_if.RX_IN = 1'b1;
    rx_if.Prescale = PW'(8);
    rx_if.PAR_EN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_values("reset");
    RST = 1'b0;
    hold(1'b1, 4);
    check_reset_values("post_reset");

    send_frame(8, 1'b1, 8'hA5, 0, 0, -1, -1);   check_events();
    send_frame(16, 1'b0, 8'h00, 3, 4, -1, -1);  check_events();
    send_frame(8, 1'b0, 8'h3C, 2, 0, -1, -1);   check_events();
    send_frame(8, 1'b1, 8'h96, 1, 0, -1, -1);   check_events();
    send_frame(8, 1'b0, 8'h42, 0, 0, -1, -1);   check_events();
    send_frame(32, 1'b0, 8'h01, 0, 0, 3, -1);
    send_frame(32, 1'b0, 8'hFF, 0, 0, 3, -1);   check_events();
    send_frame(8, 1'b1, 8'h77, 0, 0, -1, 5);    check_events();
    check_reset_values("after_abort");
    send_frame(8, 1'b0, 8'h5A, 0, 0, -1, -1);   check_events();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: p = 8;
        1: p = 16;
        default: p = 32;
      endcase
      pe = 1'($urandom);
      fault = ($urandom_range(0, 9) < 5) ? 0 : $urandom_range(1, 3);
      gb = $urandom_range(0, DW) - 1;
      send_frame(p, pe, DW'($urandom), fault, $urandom_range(1, p/2), gb, -1);
      hold(1'b1, $urandom_range(0, 4));
      check_events();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
    $finish;
  end
endmodule
